// File: rtl/lpc_cycle_arbiter.sv
// Merges LPC-captured cycle records (absolute priority) with local injector records into one FIFO.
// Records appear at the output the cycle after the write; full FIFO drops port-0 records and stalls port-1 grants.
module lpc_cycle_arbiter #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic [31:0]                tdata_i,
   input  logic                       ready_i,
   input  logic                       req1_i,
   input  logic [31:0]                data1_i,
   output logic                       gnt1_o,
   output logic                       m_valid_o,
   output logic [31:0]                m_data_o,
   output logic                       m_src_o,
   input  logic                       m_ready_i,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [CNT_W-1:0]           drop_cnt_o,
   output logic                       ovf_o,
   input  logic                       clr_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic          rdy_s1_q, rdy_s1_d;
   logic          rdy_s2_q, rdy_s2_d;
   logic          armed_q, armed_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic          ovf_q, ovf_d;
   logic [32:0]   mem_q [DEPTH];

   logic          p0_evt, p0_typed, pop, space, push, drop, gnt;
   logic [32:0]   wr_rec;

   always_comb begin
      rdy_s1_d = ready_i;
      rdy_s2_d = rdy_s1_q;
      // A level already high when reset releases must fall before it can count as an edge.
      armed_d  = armed_q | ~ready_i;

      p0_evt   = en_i & rdy_s1_q & ~rdy_s2_q & armed_q;
      p0_typed = p0_evt & (tdata_i[1:0] != 2'b00);
      pop      = m_valid_o & m_ready_i;
      space    = (level_q < LW'(DEPTH)) | pop;
      gnt      = ~rst_i & req1_i & en_i & space & ~p0_evt;
      drop     = p0_typed & ~space;
      push     = (p0_typed & space) | gnt;
      wr_rec   = p0_evt ? {1'b0, tdata_i} : {1'b1, data1_i};

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);

      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (clr_i) begin
         drop_d = '0;
         ovf_d  = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != {CNT_W{1'b1}}) drop_d = drop_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdy_s1_q <= 1'b0;
         rdy_s2_q <= 1'b0;
         armed_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         drop_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rdy_s1_q <= rdy_s1_d;
         rdy_s2_q <= rdy_s2_d;
         armed_q  <= armed_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         drop_q   <= drop_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_rec;
   end

   assign gnt1_o     = gnt;
   assign m_valid_o  = (level_q != '0);
   assign m_data_o   = mem_q[rd_ptr_q][31:0];
   assign m_src_o    = mem_q[rd_ptr_q][32];
   assign level_o    = level_q;
   assign drop_cnt_o = drop_q;
   assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_lpc_cycle_arbiter.sv
// Bench for lpc_cycle_arbiter: vector table, directed corner sequences and random traffic vs a queue model.
module tb_lpc_cycle_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i, en_i, ready_i, req1_i, m_ready_i, clr_i;
   logic [31:0] tdata_i, data1_i, m_data_o;
   logic        gnt1_o, m_valid_o, m_src_o, ovf_o;
   logic [2:0]  level_o;
   logic [7:0]  drop_cnt_o;

   lpc_cycle_arbiter #(.DEPTH(4), .CNT_W(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .tdata_i(tdata_i), .ready_i(ready_i),
      .req1_i(req1_i), .data1_i(data1_i), .gnt1_o(gnt1_o), .m_valid_o(m_valid_o),
      .m_data_o(m_data_o), .m_src_o(m_src_o), .m_ready_i(m_ready_i), .level_o(level_o),
      .drop_cnt_o(drop_cnt_o), .ovf_o(ovf_o), .clr_i(clr_i)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   logic [32:0] q[$];
   int          mdrop;
   bit          movf;
   int          hn;
   bit          h_last, h_prev;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at a negedge with inputs settled; checks outputs, advances model, moves to next negedge.
   task automatic cyc();
      bit evt, typed, pop, space, gnt;
      #1;
      if (rst_i) begin
         chk("rst_valid", m_valid_o, 0);
         chk("rst_level", level_o, 0);
         chk("rst_gnt", gnt1_o, 0);
         chk("rst_drop", drop_cnt_o, 0);
         chk("rst_ovf", ovf_o, 0);
         q.delete();
         mdrop = 0; movf = 0; hn = 0;
      end else begin
         evt   = en_i && hn >= 2 && h_last && !h_prev;
         typed = evt && (tdata_i[1:0] != 2'b00);
         pop   = (q.size() > 0) && m_ready_i;
         space = (q.size() < 4) || pop;
         gnt   = req1_i && en_i && space && !evt;
         chk("valid", m_valid_o, (q.size() > 0));
         chk("level", level_o, q.size());
         chk("gnt1", gnt1_o, gnt);
         chk("drop_cnt", drop_cnt_o, mdrop);
         chk("ovf", ovf_o, movf);
         if (q.size() > 0) begin
            chk("data", m_data_o, q[0][31:0]);
            chk("src", m_src_o, q[0][32]);
         end
         if (pop) void'(q.pop_front());
         if (typed && space) q.push_back({1'b0, tdata_i});
         else if (gnt) q.push_back({1'b1, data1_i});
         if (clr_i) begin
            mdrop = 0; movf = 0;
         end else if (typed && !space) begin
            if (mdrop < 255) mdrop++;
            movf = 1;
         end
         h_prev = h_last;
         h_last = ready_i;
         if (hn < 2) hn++;
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic pulse(input logic [31:0] td);
      ready_i = 1'b1; tdata_i = td; cyc();
      ready_i = 1'b0; cyc();
   endtask

   task automatic drain();
      ready_i = 1'b0; req1_i = 1'b0; m_ready_i = 1'b1;
      repeat (6) cyc();
   endtask

   typedef struct {
      logic        rdy;
      logic [31:0] td;
      logic        req;
      logic [31:0] d1;
      logic        mr;
      logic        e_vld;
      logic [2:0]  e_lvl;
      logic        e_gnt;
      logic [31:0] e_dat;
      logic        e_src;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{1'b1, 32'h0123_4AB1, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
      tbl[1] = '{1'b1, 32'h0123_4AB1, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
      tbl[2] = '{1'b0, 32'h0123_4AB1, 1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b0, 32'h0123_4AB1, 1'b0};
      tbl[3] = '{1'b0, 32'h0123_4AB1, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
      tbl[4] = '{1'b1, 32'hAAAA_0002, 1'b0, 32'h1111_1111, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
      tbl[5] = '{1'b1, 32'hAAAA_0002, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};
      tbl[6] = '{1'b0, 32'hAAAA_0002, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 3'd1, 1'b1, 32'hAAAA_0002, 1'b0};
      tbl[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd2, 1'b0, 32'hAAAA_0002, 1'b0};
      tbl[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b0, 32'h1111_1111, 1'b1};
      tbl[9] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 1'b0};

      rst_i = 1'b1; en_i = 1'b1; ready_i = 1'b0; req1_i = 1'b0; m_ready_i = 1'b0;
      clr_i = 1'b0; tdata_i = '0; data1_i = '0;
      q.delete(); mdrop = 0; movf = 0; hn = 0; h_last = 0; h_prev = 0;
      @(negedge clk_i);
      cyc();
      rst_i = 1'b0;
      cyc();
      cyc();

      // Single LPC write then port-0/port-1 collision
      for (int i = 0; i < 10; i++) begin
         ready_i = tbl[i].rdy; tdata_i = tbl[i].td; req1_i = tbl[i].req;
         data1_i = tbl[i].d1; m_ready_i = tbl[i].mr;
         #1;
         chk($sformatf("tbl%0d_vld", i), m_valid_o, tbl[i].e_vld);
         chk($sformatf("tbl%0d_lvl", i), level_o, tbl[i].e_lvl);
         chk($sformatf("tbl%0d_gnt", i), gnt1_o, tbl[i].e_gnt);
         if (tbl[i].e_vld) begin
            chk($sformatf("tbl%0d_dat", i), m_data_o, tbl[i].e_dat);
            chk($sformatf("tbl%0d_src", i), m_src_o, tbl[i].e_src);
         end
         cyc();
      end

      // Overflow: six events into a stalled FIFO
      m_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) pulse(32'h1000_0001 + 32'(i * 16));
      chk("ovf_level", level_o, 4);
      chk("ovf_drop", drop_cnt_o, 2);
      chk("ovf_flag", ovf_o, 1);
      m_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_order%0d", i), m_data_o, 32'h1000_0001 + 32'(i * 16));
         cyc();
      end
      chk("ovf_empty", m_valid_o, 0);
      clr_i = 1'b1; cyc(); clr_i = 1'b0;
      chk("clr_drop", drop_cnt_o, 0);
      chk("clr_ovf", ovf_o, 0);

      // Full FIFO with a pop and a port-0 event in the same cycle
      m_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) pulse(32'h2000_0003 + 32'(i * 16));
      ready_i = 1'b1; tdata_i = 32'h2000_0443; cyc();
      ready_i = 1'b0; m_ready_i = 1'b1; cyc();
      m_ready_i = 1'b0;
      chk("full_pop_level", level_o, 4);
      chk("full_pop_drop", drop_cnt_o, 0);
      chk("full_pop_head", m_data_o, 32'h2000_0013);
      drain();

      // Reset mid-burst with ready held high
      m_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) pulse(32'h3000_0002 + 32'(i * 16));
      chk("pre_rst_level", level_o, 3);
      ready_i = 1'b1; tdata_i = 32'h3000_0FF2; cyc();
      rst_i = 1'b1;
      #1;
      chk("rst_async_valid", m_valid_o, 0);
      cyc();
      rst_i = 1'b0;
      repeat (3) cyc();
      chk("rst_no_capture", level_o, 0);
      ready_i = 1'b0; cyc();
      ready_i = 1'b1; cyc();
      cyc();
      chk("rst_fresh_edge", level_o, 1);
      drain();

      // Drop-counter saturation and clear against a coincident drop
      m_ready_i = 1'b0;
      for (int i = 0; i < 4; i++) pulse(32'h4000_0001 + 32'(i * 16));
      for (int i = 0; i < 300; i++) pulse(32'h5000_0001);
      chk("sat_drop", drop_cnt_o, 255);
      chk("sat_ovf", ovf_o, 1);
      ready_i = 1'b1; tdata_i = 32'h5000_0002; cyc();
      ready_i = 1'b0; clr_i = 1'b1; cyc();
      clr_i = 1'b0;
      chk("clr_vs_drop_cnt", drop_cnt_o, 0);
      chk("clr_vs_drop_ovf", ovf_o, 0);
      drain();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         ready_i   = ($urandom_range(0, 2) != 0) ? ~ready_i : ready_i;
         tdata_i   = $urandom;
         req1_i    = ($urandom_range(0, 2) == 0);
         data1_i   = $urandom;
         m_ready_i = ($urandom_range(0, 3) != 0);
         en_i      = ($urandom_range(0, 7) != 0);
         clr_i     = ($urandom_range(0, 49) == 0);
         rst_i     = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst_i = 1'b0; en_i = 1'b1; clr_i = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lpc_cycle_arbiter.md
LPC_CYCLE_ARBITER -- requirements
Module: lpc_cycle_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning record FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 8, meaning drop-counter width.
REQ-003 SHALL have port clk_i, input, 1, meaning the LPC clock and the only clock.
REQ-004 SHALL have port rst_i, input, 1, meaning reset, asynchronous and active-high.
REQ-005 SHALL have port en_i, input, 1, meaning capture enable for both sources.
REQ-006 SHALL have port tdata_i, input, 32, meaning port-0 cycle record (addr/data/type) from the LPC peripheral.
REQ-007 SHALL have port ready_i, input, 1, meaning port-0 record-valid level; may stay high for several cycles.
REQ-008 SHALL have port req1_i, input, 1, meaning port-1 (local injector) request.
REQ-009 SHALL have port data1_i, input, 32, meaning port-1 record.
REQ-010 SHALL have port gnt1_o, output, 1, meaning one-cycle port-1 grant (record accepted).
REQ-011 SHALL have port m_valid_o, output, 1, meaning output record valid.
REQ-012 SHALL have port m_data_o, output, 32, meaning output record (FIFO head).
REQ-013 SHALL have port m_src_o, output, 1, meaning source of head record (0 = LPC, 1 = injector).
REQ-014 SHALL have port m_ready_i, input, 1, meaning consumer accept.
REQ-015 SHALL have port level_o, output, clog2(DEPTH)+1, meaning FIFO occupancy.
REQ-016 SHALL have port drop_cnt_o, output, CNT_W, meaning count of dropped port-0 records.
REQ-017 SHALL have port ovf_o, output, 1, meaning sticky overflow flag.
REQ-018 SHALL have port clr_i, input, 1, meaning synchronous clear of drop_cnt_o and ovf_o.

Function
REQ-019 SHALL register ready_i and detect a port-0 event only on a 0->1 transition while en_i=1; a held-high level SHALL produce exactly one event.
REQ-020 SHALL discard a port-0 event whose tdata_i[1:0]=2'b00 (no cycle type), without counting it as a drop.
REQ-021 SHALL treat a pop as m_valid_o & m_ready_i, and SHALL treat space as level_o<DEPTH or a pop in the same cycle.
REQ-022 SHALL give port 0 absolute priority; a port-0 event SHALL be written in the same cycle it is detected, with m_src=0.
REQ-023 SHALL drop a port-0 event when no space exists; drop_cnt_o SHALL then increment, saturating at all-ones, and ovf_o SHALL set.
REQ-024 SHALL assert gnt1_o and write data1_i (m_src=1) only when req1_i=1, en_i=1, space exists and no port-0 event occurs that cycle.
REQ-025 SHALL NOT grant port 1 with a one-cycle lookahead: if a port-0 event and req1_i coincide, port 1 SHALL wait at least one more cycle.
REQ-026 SHALL hold m_valid_o=1 whenever level_o>0; m_data_o and m_src_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-027 SHALL present a written record at the output no earlier than the cycle after the write; latency from ready_i rising to m_valid_o is 2 cycles when the FIFO is empty.
REQ-028 SHALL handle a simultaneous push and pop: level_o SHALL be unchanged, order SHALL be preserved, and the read and write pointers SHALL wrap modulo DEPTH.
REQ-029 SHALL give clr_i priority over a same-cycle increment; in that cycle drop_cnt_o=0 and ovf_o=0.
REQ-030 SHALL, when en_i=0, block new captures and grants, while draining to the output SHALL continue.

Reset
REQ-031 SHALL, while rst_i=1 and asynchronously, set the pointers to 0, level_o=0, m_valid_o=0, gnt1_o=0, drop_cnt_o=0, ovf_o=0 and the ready_i edge register to 0.
REQ-032 SHALL discard any record in flight when reset is asserted mid-operation; after release, the first event SHALL be detected only on a fresh ready_i rising edge.
REQ-033 SHALL leave FIFO storage contents unreset; m_data_o is don't-care while m_valid_o=0.

Verification
REQ-034 Single LPC write: ready_i held high 2 cycles, tdata_i=0x0123_4AB1, m_ready_i=1 -> exactly one output record 0x01234AB1 with m_src_o=0, m_valid_o high 2 cycles after the edge.
REQ-035 Overflow: m_ready_i=0, 6 port-0 events -> level_o=4, drop_cnt_o=2, ovf_o=1; then 4 pops -> records come out in order of the first 4 events.
REQ-036 Collision: port-0 event and req1_i in the same cycle, FIFO empty -> port-0 record first, gnt1_o next cycle, output order LPC then injector.
REQ-037 Full with simultaneous pop and port-0 event -> no drop, level_o stays 4, wrap-around order correct.
REQ-038 Mid-burst reset: rst_i pulsed with level_o=3 and ready_i held high -> m_valid_o=0 immediately, no capture until ready_i falls and rises again.
REQ-039 Saturation/clear: force 300 drops (CNT_W=8) -> drop_cnt_o=255; clr_i together with a drop -> drop_cnt_o=0 and ovf_o=0.
